// File: rtl/ks_pkg.sv
// ks_pkg: shared definitions for the multi-precision Kogge-Stone adder.
//   LIMB_W     - width of one limb (the width of KS_Adder).
//   mw_state_t - sequencer states of multiword_ks_adder.
package ks_pkg;
  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mw_state_t;
endpackage

// File: rtl/KS_Adder.sv
// KS_Adder: 16-bit combinational Kogge-Stone adder.
//   A, B : in  LIMB_W  operands
//   Ci   : in  1       carry-in
//   S    : out LIMB_W  sum
//   Co   : out 1       carry-out
// The carry-in is folded in as an extra generate-only position below bit 0,
// so the prefix tree spans LIMB_W+1 positions and needs one more level.
module KS_Adder
  import ks_pkg::*;
(
  input  logic [LIMB_W-1:0] A,
  input  logic [LIMB_W-1:0] B,
  input  logic              Ci,
  output logic [LIMB_W-1:0] S,
  output logic              Co
);
  localparam int N = LIMB_W + 1;

  always_comb begin
    logic [N-1:0] g, p, gn, pn, p0;
    g  = {A & B, Ci};
    p  = {A ^ B, 1'b0};
    p0 = p;
    // Prefix levels with span doubling: 1, 2, 4, 8, 16.
    for (int d = 1; d < N; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = N - 1; i >= d; i--) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    // g[i] is now the carry into sum bit i.
    S  = p0[N-1:1] ^ g[N-2:0];
    Co = g[N-1];
  end
endmodule

// File: rtl/multiword_ks_adder.sv
// multiword_ks_adder: sequential WORDS x 16-bit adder built on one KS_Adder.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : operand handshake (A, B, Ci)
//   out_valid/out_ready: result handshake (S, Co)
//   S = (A + B + Ci) mod 2^W, Co = carry out of the top limb.
// One limb per cycle, LSB limb first; operands sit in right-shift registers
// so the adder always sees the low limb. Latency WORDS cycles from accept.
module multiword_ks_adder
  import ks_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LIMB_W*WORDS-1:0] A,
  input  logic [LIMB_W*WORDS-1:0] B,
  input  logic                    Ci,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LIMB_W*WORDS-1:0] S,
  output logic                    Co
);
  localparam int W  = LIMB_W * WORDS;
  localparam int CW = $clog2(WORDS);

  mw_state_t                    r_state, w_state_nxt;
  logic [W-1:0]                 r_a, r_b;
  logic                         r_carry;
  logic [CW-1:0]                r_cnt, w_cnt_inc;
  logic [WORDS-1:0][LIMB_W-1:0] r_s;
  logic                         r_co;
  logic [LIMB_W-1:0]            w_sum;
  logic                         w_co;
  logic                         w_accept;
  logic                         w_last;

  KS_Adder u_ks (
    .A  (r_a[LIMB_W-1:0]),
    .B  (r_b[LIMB_W-1:0]),
    .Ci (r_carry),
    .S  (w_sum),
    .Co (w_co)
  );

  // Counter increment without an adder: bit i toggles when all lower bits are 1.
  always_comb begin
    w_cnt_inc = '0;
    for (int i = CW - 1; i >= 0; i--) begin
      w_cnt_inc[i] = r_cnt[i] ^ (&(r_cnt | ~CW'((1 << i) - 1)));
    end
  end

  assign w_last = (r_cnt == CW'(WORDS - 1));

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        // Handoff and next accept share one edge.
        in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_co    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= A;
        r_b     <= B;
        r_carry <= Ci;
        r_cnt   <= '0;
      end
      if (r_state == RUN) begin
        r_s[r_cnt] <= w_sum;
        r_carry    <= w_co;
        r_a        <= r_a >> LIMB_W;
        r_b        <= r_b >> LIMB_W;
        r_cnt      <= w_cnt_inc;
        if (w_last) r_co <= w_co;
      end
    end
  end

  assign S  = r_s;
  assign Co = r_co;
endmodule

// File: tb/tb_multiword_ks_adder.sv
module tb_multiword_ks_adder;
  localparam int WORDS = 4;
  localparam int W     = 64;
  localparam int NOPS  = 10000;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, Ci, out_valid, out_ready, Co;
  logic [W-1:0] A, B, S;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  multiword_ks_adder #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Ci        (Ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Co        (Co)
  );

  // Reference: plain wide arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  // Called at a negedge with the DUT able to accept; returns at the negedge after the accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    A = a; B = b; Ci = ci; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges until out_valid; n = edges since the accept edge, 99 on timeout.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) n = 99;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Ci = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_during_rst got=%b exp=0", in_ready); end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== '0 || Co !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got in_ready=%b out_valid=%b S=%h Co=%b exp 1 0 0 0", in_ready, out_valid, S, Co);
    end
  endtask

  task automatic test_single_carry();
    int n;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got=%b exp=1", in_ready); end
    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0);
    wait_valid(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL single_latency got=%0d exp=4", n); end
    checks++;
    if (S !== 64'h0000_0000_0001_0000 || Co !== 1'b0) begin
      errors++; $display("FAIL single_sum got=%b_%h exp=0_0000000000010000", Co, S);
    end
    consume();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_consumed got=%b exp=0", out_valid); end
  endtask

  task automatic test_full_ripple();
    int n;
    logic [W-1:0] ea [2];
    logic [W-1:0] eb [2];
    logic         ec [2];
    logic [W:0]   ex [2];
    ea[0] = '1; eb[0] = '0; ec[0] = 1'b1; ex[0] = {1'b1, 64'h0};
    ea[1] = '1; eb[1] = '1; ec[1] = 1'b0; ex[1] = {1'b1, 64'hFFFF_FFFF_FFFF_FFFE};
    for (int k = 0; k < 2; k++) begin
      start_op(ea[k], eb[k], ec[k]);
      wait_valid(n);
      checks++;
      if ({Co, S} !== ex[k]) begin
        errors++; $display("FAIL full_ripple_%0d got=%h exp=%h", k, {Co, S}, ex[k]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [W-1:0] xa, xb, ya, yb;
    logic         xc, yc;
    logic [W:0]   xe;
    xa = {$urandom, $urandom}; xb = {$urandom, $urandom}; xc = 1'b1;
    ya = {$urandom, $urandom}; yb = {$urandom, $urandom}; yc = 1'b0;
    xe = model(xa, xb, xc);
    start_op(xa, xb, xc);
    wait_valid(n);
    A = ya; B = yb; Ci = yc; in_valid = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {Co, S} !== xe) begin
        errors++;
        $display("FAIL backpressure_hold_%0d got ov=%b ir=%b sum=%h exp ov=1 ir=0 sum=%h", k, out_valid, in_ready, {Co, S}, xe);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_release_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL backpressure_handoff got=%b exp=0", out_valid); end
    wait_valid(n);
    checks++;
    if (n != 4) begin errors++; $display("FAIL backpressure_next_latency got=%0d exp=4", n); end
    checks++;
    if ({Co, S} !== model(ya, yb, yc)) begin
      errors++; $display("FAIL backpressure_next_sum got=%h exp=%h", {Co, S}, model(ya, yb, yc));
    end
    consume();
  endtask

  task automatic test_run_ignored();
    int n;
    logic [W-1:0] xa, xb;
    xa = {$urandom, $urandom}; xb = {$urandom, $urandom};
    start_op(xa, xb, 1'b1);
    for (int k = 0; k < 3; k++) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; Ci = 1'b0; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL run_ready_%0d got=%b exp=0", k, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if ({Co, S} !== model(xa, xb, 1'b1)) begin
      errors++; $display("FAIL run_ignored_sum got=%h exp=%h", {Co, S}, model(xa, xb, 1'b1));
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int  n;
    bit  seen;
    logic [W-1:0] ya, yb;
    start_op(64'h1234_5678_9ABC_DEF0, 64'h1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || S !== '0 || Co !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset got ir=%b ov=%b S=%h Co=%b exp 1 0 0 0", in_ready, out_valid, S, Co);
    end
    seen = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL midop_no_result got=1 exp=0"); end
    ya = {$urandom, $urandom}; yb = {$urandom, $urandom};
    start_op(ya, yb, 1'b1);
    wait_valid(n);
    checks++;
    if (n != 4 || {Co, S} !== model(ya, yb, 1'b1)) begin
      errors++; $display("FAIL midop_following got lat=%0d sum=%h exp lat=4 sum=%h", n, {Co, S}, model(ya, yb, 1'b1));
    end
    consume();
  endtask

  task automatic test_random();
    int           sent, recv, cyc, bad;
    bit           have;
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   q [$];
    logic [W:0]   ex;
    sent = 0; recv = 0; cyc = 0; bad = 0; have = 1'b0;
    ra = '0; rb = '0; rc = 1'b0;
    while (recv < NOPS && cyc < 90000) begin
      @(negedge clk);
      cyc++;
      if (!have && sent < NOPS) begin
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 3) == 0) ? ~ra : {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        have = 1'b1;
      end
      A = ra; B = rb; Ci = rc;
      in_valid  = have && ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) != 0);
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL random_extra_result got=%h exp=none", {Co, S});
        end else begin
          ex = q.pop_front();
          if ({Co, S} !== ex) begin
            errors++; bad++;
            if (bad <= 10) $display("FAIL random_sum #%0d got=%h exp=%h", recv, {Co, S}, ex);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(ra, rb, rc));
        sent++;
        have = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (recv != NOPS || q.size() != 0) begin
      errors++; $display("FAIL random_count got=%0d pending=%0d exp=%0d pending=0", recv, q.size(), NOPS);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Ci = 1'b0;
    test_reset();
    test_single_carry();
    test_full_ripple();
    test_backpressure();
    test_run_ignored();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
